switch_conditioner: RTL and testbench

Input-conditioning stage that sits directly upstream of the exponent accelerator system's 10-bit switch PIO input. It synchronises the raw board slide switches, debounces each bit independently, and drives the clean level onto the system's switch input. It also produces per-bit rise and fall pulses and a sticky change-pending flag with an acknowledge handshake, so firmware-side or fabric logic never sees switch bounce.

---
 rtl/switch_conditioner_pkg.sv | 11 +
 rtl/switch_conditioner_if.sv | 37 +++
 rtl/switch_conditioner_debounce_bit.sv | 51 +++++
 rtl/switch_conditioner.sv | 60 ++++++
 tb/tb_switch_conditioner.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/switch_conditioner_pkg.sv
// Shared constants for the slide-switch conditioning stage.
// Board timing: 20 ms of settled level at 50 MHz before a new switch level is accepted.
package switch_cond_pkg;

    localparam int SW_WIDTH                = 10;
    localparam int CLK_HZ                  = 50000000;
    localparam int DEBOUNCE_MS             = 20;
    localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int SIM_DEBOUNCE_CYCLES     = 4;

endpackage

// File: rtl/switch_conditioner_if.sv
// Switch-side bundle: raw pins in, clean level / edge pulses / sticky change flag out.
// change_ack is level-sampled each clock; while high the sticky mask keeps only same-cycle flips.
interface switch_conditioner_if
    import switch_cond_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH
);

    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] switch_export;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             change_valid;
    logic [WIDTH-1:0] change_mask;
    logic             change_ack;

    modport master (
        input  sw_raw,
        input  change_ack,
        output switch_export,
        output sw_rise,
        output sw_fall,
        output change_valid,
        output change_mask
    );

    modport slave (
        output sw_raw,
        output change_ack,
        input  switch_export,
        input  sw_rise,
        input  sw_fall,
        input  change_valid,
        input  change_mask
    );

endinterface

// File: rtl/switch_conditioner_debounce_bit.sv
// One switch bit: two-flop synchroniser, consecutive-mismatch counter, accepted level
// and registered rise/fall pulses that coincide with the level update.
module debounce_bit
    import switch_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam int             CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // High in the cycle the accepted level is about to change.
    assign flip = (s2 != stable) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= flip & s2;
            fall <= flip & ~s2;
            if (flip) begin
                stable <= s2;
                cnt    <= '0;
            end else if (s2 == stable) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Debounces WIDTH slide switches independently and keeps a sticky record of which
// bits changed since firmware last acknowledged.
module switch_conditioner
    import switch_cond_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    switch_conditioner_if.master sw
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_next;
    logic             valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk    (clk_clk),
            .rst_n  (reset_reset_n),
            .raw    (sw.sw_raw[i]),
            .stable (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .flip   (flip[i])
        );
    end

    // An ack coinciding with a fresh flip keeps that flip pending.
    always_comb begin
        mask_next = mask_q | flip;
        if (sw.change_ack) begin
            mask_next = flip;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            mask_q  <= mask_next;
            valid_q <= |mask_next;
        end
    end

    assign sw.switch_export = level;
    assign sw.sw_rise       = rise;
    assign sw.sw_fall       = fall;
    assign sw.change_mask   = mask_q;
    assign sw.change_valid  = valid_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus random switch activity,
// checked every cycle against a window-based reference model through a queue.
module tb_switch_conditioner;
    import switch_cond_pkg::*;

    localparam int W = SW_WIDTH;
    localparam int D = SIM_DEBOUNCE_CYCLES;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    switch_conditioner_if #(.WIDTH(W)) sw ();

    switch_conditioner #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .sw            (sw)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A level is accepted once the last D synchronised samples all disagree with it.
    logic [4*W:0] exp_q[$];
    logic [W-1:0] raw_q[$];
    logic [W-1:0] win_q[$];
    logic [W-1:0] m_level;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_d;
    logic [W-1:0] m_flips;
    logic         m_all;

    always @(posedge clk) begin
        if (!rst_n) begin
            raw_q.delete();
            raw_q.push_back('0);
            raw_q.push_back('0);
            win_q.delete();
            m_level = '0;
            m_mask  = '0;
        end else begin
            m_d = raw_q.pop_front();
            raw_q.push_back(sw.sw_raw);
            win_q.push_back(m_d);
            if (win_q.size() > D) void'(win_q.pop_front());
            m_flips = '0;
            if (win_q.size() == D) begin
                for (int i = 0; i < W; i++) begin
                    m_all = 1'b1;
                    foreach (win_q[j]) if (win_q[j][i] == m_level[i]) m_all = 1'b0;
                    m_flips[i] = m_all;
                end
            end
            m_level = m_level ^ m_flips;
            m_mask  = sw.change_ack ? m_flips : (m_mask | m_flips);
            exp_q.push_back({m_level, m_flips & m_level, m_flips & ~m_level, |m_mask, m_mask});
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [4*W:0] exp_rec;
    logic [4*W:0] act_rec;

    always @(posedge clk) begin
        #1;
        act_rec = {sw.switch_export, sw.sw_rise, sw.sw_fall, sw.change_valid, sw.change_mask};
        if (!rst_n) begin
            check("reset_outputs", 64'(act_rec), 64'd0);
        end else if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 64'd0, 64'd1);
        end else begin
            exp_rec = exp_q.pop_front();
            check("cycle_outputs", 64'(act_rec), 64'(exp_rec));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic [W-1:0] r, input logic a);
        @(negedge clk);
        sw.sw_raw     = r;
        sw.change_ack = a;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_once(input logic [W-1:0] r);
        step(r, 1'b1);
        step(r, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] cur;

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        sw.sw_raw     = 10'h3FF;
        sw.change_ack = 1'b0;

        // 1: switches up at power-up
        repeat (3) @(posedge clk);
        #1 check("s1_reset_export", 64'(sw.switch_export), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("s1_export_early", 64'(sw.switch_export), 64'd0);
        @(posedge clk);
        #1;
        check("s1_export", 64'(sw.switch_export), 64'h3FF);
        check("s1_rise", 64'(sw.sw_rise), 64'h3FF);
        check("s1_valid", 64'(sw.change_valid), 64'd1);
        check("s1_mask", 64'(sw.change_mask), 64'h3FF);
        @(posedge clk);
        #1 check("s1_rise_one_cycle", 64'(sw.sw_rise), 64'd0);

        // 2: single bit rise with exact latency
        step(10'h000, 1'b0);
        idle(8);
        ack_once(10'h000);
        step(10'h008, 1'b0);
        repeat (5) @(posedge clk);
        #1 check("s2_export_early", 64'(sw.switch_export), 64'd0);
        @(posedge clk);
        #1;
        check("s2_export", 64'(sw.switch_export), 64'h008);
        check("s2_rise", 64'(sw.sw_rise), 64'h008);
        check("s2_fall", 64'(sw.sw_fall), 64'd0);
        check("s2_mask", 64'(sw.change_mask), 64'h008);

        // 3: bounce shorter than the debounce window is rejected
        ack_once(10'h008);
        repeat (3) step(10'h009, 1'b0);
        step(10'h008, 1'b0);
        repeat (3) step(10'h009, 1'b0);
        step(10'h008, 1'b0);
        idle(8);
        check("s3_export", 64'(sw.switch_export), 64'h008);
        check("s3_valid", 64'(sw.change_valid), 64'd0);

        // 4: ack in the same cycle as a new flip
        step(10'h020, 1'b0);
        idle(8);
        ack_once(10'h020);
        step(10'h028, 1'b0);
        idle(8);
        check("s4_mask_setup", 64'(sw.change_mask), 64'h008);
        step(10'h008, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk) sw.change_ack = 1'b1;
        @(posedge clk);
        #1;
        check("s4_fall", 64'(sw.sw_fall), 64'h020);
        check("s4_mask_ack_flip", 64'(sw.change_mask), 64'h020);
        check("s4_valid_ack_flip", 64'(sw.change_valid), 64'd1);
        @(posedge clk);
        #1;
        check("s4_mask_lone_ack", 64'(sw.change_mask), 64'd0);
        check("s4_valid_lone_ack", 64'(sw.change_valid), 64'd0);
        @(negedge clk) sw.change_ack = 1'b0;

        // 5: reset in the middle of a count
        step(10'h00C, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1 check("s5_async_export", 64'(sw.switch_export), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("s5_export_early", 64'(sw.switch_export), 64'd0);
        @(posedge clk);
        #1;
        check("s5_export", 64'(sw.switch_export), 64'h00C);
        check("s5_rise", 64'(sw.sw_rise), 64'h00C);

        // 6: simultaneous rises and fall
        step(10'h01C, 1'b0);
        idle(8);
        ack_once(10'h01C);
        step(10'h08E, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("s6_rise", 64'(sw.sw_rise), 64'h082);
        check("s6_fall", 64'(sw.sw_fall), 64'h010);
        check("s6_mask", 64'(sw.change_mask), 64'h092);
        check("s6_export", 64'(sw.switch_export), 64'h08E);

        // random switch activity with occasional acks
        cur = 10'h08E;
        repeat (60) begin
            cur = cur ^ W'($urandom_range(0, (1 << W) - 1) & $urandom_range(0, (1 << W) - 1));
            repeat ($urandom_range(1, 8)) step(cur, ($urandom_range(0, 3) == 0));
        end
        step(cur, 1'b0);
        idle(10);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
